// File: rtl/seg_pkg.sv
// Shared definitions for the 8-digit 7-segment display path.
// The core's segment encoder also uses these, so they live in a package
// and not in the scan driver.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned IDX_W      = 3;

  // Active-low pattern with every segment and the dp off.
  localparam logic [SEG_W-1:0] SEG_NONE = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Active-low anode vector with only digit idx enabled.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] an;
    an      = '1;
    an[idx] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the display scan. It tracks the phase (BLANK/SHOW), the
// digit index and the cycle count within the phase. The parent samples the
// next-state outputs so its own registered outputs change on the same edge
// as the state they reflect.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output scan_state_t      state_next_o,
  output logic [IDX_W-1:0] idx_next_o,
  output logic             snap_o,       // current cycle is the frame-snapshot slot
  output logic             frame_end_o   // this edge ends SHOW of the last digit
);

  localparam int unsigned CntW = $clog2(DIGIT_CYCLES);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(DIGIT_CYCLES - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             frame_end;

  // Next-state: count through the phase, flip phase at its last cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CntW'(1);
    frame_end = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == ShowLast) begin
          cnt_d     = '0;
          state_d   = BLANK;
          idx_d     = idx_q + IDX_W'(1);  // 7 wraps to 0
          frame_end = (idx_q == IdxLast);
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_next_o = state_d;
  assign idx_next_o   = idx_d;
  assign snap_o       = (state_q == BLANK) && (idx_q == '0) && (cnt_q == '0);
  assign frame_end_o  = frame_end;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Each frame is snapshotted into shadow registers at its first edge so the
// display never tears; each digit slot opens with a blanking interval.
// Optional build macro SEG_SCAN_DIM_EN adds dim_i and a 3-bit PWM duty gate.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [SEG_W-1:0]      seg0_i,
  input  logic [SEG_W-1:0]      seg1_i,
  input  logic [SEG_W-1:0]      seg2_i,
  input  logic [SEG_W-1:0]      seg3_i,
  input  logic [SEG_W-1:0]      seg4_i,
  input  logic [SEG_W-1:0]      seg5_i,
  input  logic [SEG_W-1:0]      seg6_i,
  input  logic [SEG_W-1:0]      seg7_i,
  input  logic                  freeze_i,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]            dim_i,
`endif
  output logic [SEG_W-1:0]      seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  frame_o
);

  scan_state_t      state_next;
  logic [IDX_W-1:0] idx_next;
  logic             snap;
  logic             frame_end;

  seg_scan_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .state_next_o (state_next),
    .idx_next_o   (idx_next),
    .snap_o       (snap),
    .frame_end_o  (frame_end)
  );

  logic [SEG_W-1:0]      seg_in   [NUM_DIGITS];
  logic [SEG_W-1:0]      shadow_q [NUM_DIGITS];
  logic [SEG_W-1:0]      shadow_d [NUM_DIGITS];
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q;
  logic                  dim_on;

  assign seg_in[0] = seg0_i;
  assign seg_in[1] = seg1_i;
  assign seg_in[2] = seg2_i;
  assign seg_in[3] = seg3_i;
  assign seg_in[4] = seg4_i;
  assign seg_in[5] = seg5_i;
  assign seg_in[6] = seg6_i;
  assign seg_in[7] = seg7_i;

`ifdef SEG_SCAN_DIM_EN
  logic [2:0] pwm_q, pwm_d;

  assign pwm_d = pwm_q + 3'd1;
  // Gate against the PWM value of the cycle being loaded: on when pwm < dim+1.
  assign dim_on = (pwm_d <= dim_i);

  // Free-running PWM phase counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`else
  assign dim_on = 1'b1;
`endif

  // Frame snapshot: load all digits together unless frozen.
  always_comb begin
    shadow_d = shadow_q;
    if (snap && !freeze_i) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_d[k] = seg_in[k];
      end
    end
  end

  // Output decode from the timer's next state; shadow_d keeps the snapshot
  // visible even when the blank phase is a single cycle.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_NONE;
    if (state_next == SHOW) begin
      seg_d = shadow_d[idx_next];
      if (dim_on) begin
        an_d = anode_sel(idx_next);
      end
    end
  end

  // Shadow and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= SEG_NONE;
      end
      seg_q   <= SEG_NONE;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      frame_q  <= frame_end;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Reference: cycle t (t=1 is the cycle after the reset edge) sits at frame
// position p=(t-1)%64, digit p/8, offset p%8; offsets >= 2 show the digit.
module tb_seg_scan_driver;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FR = 8 * DC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       freeze = 1'b0;
  logic [7:0] seg_in [8];
  logic [7:0] seg_o;
  logic [7:0] an_o;
  logic       frame_o;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0] dim = 3'd7;
`endif
  logic [2:0] dim_edge = 3'd7;

  seg_scan_driver #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .seg0_i   (seg_in[0]),
    .seg1_i   (seg_in[1]),
    .seg2_i   (seg_in[2]),
    .seg3_i   (seg_in[3]),
    .seg4_i   (seg_in[4]),
    .seg5_i   (seg_in[5]),
    .seg6_i   (seg_in[6]),
    .seg7_i   (seg_in[7]),
    .freeze_i (freeze),
`ifdef SEG_SCAN_DIM_EN
    .dim_i    (dim),
`endif
    .seg_o    (seg_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         t = 0;
  int         abs_cyc = 0;
  int         last_frame = -1;
  logic [7:0] mshadow [8];

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [7:0] exp_an(input int tt);
    int p;
    logic [7:0] a;
    p = (tt - 1) % FR;
    a = 8'hFF;
    if ((p % DC) >= BC) a[p / DC] = 1'b0;
    if (((tt - 1) % 8) > int'(dim_edge)) a = 8'hFF;
    return a;
  endfunction

  function automatic logic [7:0] exp_seg(input int tt);
    int p;
    p = (tt - 1) % FR;
    if ((p % DC) >= BC) return mshadow[p / DC];
    return 8'hFF;
  endfunction

  function automatic logic exp_frame(input int tt);
    return (tt > 1) && (((tt - 1) % FR) == 0);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  // Advance one clock; the model snapshots the inputs driven for the edge
  // that ends the first cycle of a frame.
  task automatic step(input bit model_chk);
    if (!rst && t >= 1 && ((t - 1) % FR) == 0 && !freeze) mshadow = seg_in;
`ifdef SEG_SCAN_DIM_EN
    dim_edge = dim;
`endif
    @(posedge clk);
    #1;
    abs_cyc++;
    if (rst) begin
      t = 1;
      last_frame = -1;
      foreach (mshadow[k]) mshadow[k] = 8'hFF;
    end else begin
      t++;
    end
    checks++;
    if ($countones(~an_o) > 1) begin
      errors++;
      $display("FAIL onehot at cycle %0d: an_o %h has more than one active anode", t, an_o);
    end
    if (frame_o) begin
      if (last_frame >= 0) begin
        checks++;
        if (abs_cyc - last_frame != FR) begin
          errors++;
          $display("FAIL frame_period: got %0d expected %0d", abs_cyc - last_frame, FR);
        end
      end
      last_frame = abs_cyc;
    end
    if (model_chk) begin
      chk("an_model", an_o, exp_an(t));
      chk("seg_model", seg_o, exp_seg(t));
      chk("frame_model", {7'b0, frame_o}, {7'b0, exp_frame(t)});
    end
  endtask

  initial begin
    tbl[0]  = '{1,  8'hFF, 8'hFF, 1'b0};
    tbl[1]  = '{2,  8'hFF, 8'hFF, 1'b0};
    tbl[2]  = '{3,  8'hFE, 8'h00, 1'b0};
    tbl[3]  = '{8,  8'hFE, 8'h00, 1'b0};
    tbl[4]  = '{9,  8'hFF, 8'hFF, 1'b0};
    tbl[5]  = '{11, 8'hFD, 8'h01, 1'b0};
    tbl[6]  = '{16, 8'hFD, 8'h01, 1'b0};
    tbl[7]  = '{35, 8'hEF, 8'h04, 1'b0};
    tbl[8]  = '{59, 8'h7F, 8'h07, 1'b0};
    tbl[9]  = '{64, 8'h7F, 8'h07, 1'b0};
    tbl[10] = '{65, 8'hFF, 8'hFF, 1'b1};
    tbl[11] = '{66, 8'hFF, 8'hFF, 1'b0};

    // Basic scan with patterns 00..07.
    for (int k = 0; k < 8; k++) seg_in[k] = 8'(k);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      while (t < tbl[i].cyc) step(1'b0);
      chk($sformatf("tbl%0d_an", i), an_o, tbl[i].an);
      chk($sformatf("tbl%0d_seg", i), seg_o, tbl[i].seg);
      chk($sformatf("tbl%0d_frame", i), {7'b0, frame_o}, {7'b0, tbl[i].frame});
    end

    // Mid-frame input change is held until the next snapshot.
    seg_in[3] = 8'hAA;
    while (t < 91) step(1'b1);
    chk("hold_d3", seg_o, 8'h03);
    while (t < 155) step(1'b1);
    chk("new_d3", seg_o, 8'hAA);

    // Freeze across a snapshot edge, then release.
    while (t < 193) step(1'b1);
    foreach (seg_in[k]) seg_in[k] = 8'h55;
    freeze = 1'b1;
    step(1'b1);
    freeze = 1'b0;
    while (t < 219) step(1'b1);
    chk("frz_d3", seg_o, 8'hAA);
    while (t < 259) step(1'b1);
    chk("rel_d0_seg", seg_o, 8'h55);
    chk("rel_d0_an", an_o, 8'hFE);

    // Reset during SHOW of digit 5, first snapshot then skipped by freeze.
    while (t < 300) step(1'b1);
    chk("pre_rst_an", an_o, 8'hDF);
    rst = 1'b1;
    freeze = 1'b1;
    step(1'b1);
    chk("rst_an", an_o, 8'hFF);
    chk("rst_seg", seg_o, 8'hFF);
    chk("rst_frame", {7'b0, frame_o}, 8'h00);
    rst = 1'b0;
    step(1'b1);
    freeze = 1'b0;
    step(1'b1);
    chk("rst_shadow_seg", seg_o, 8'hFF);
    chk("rst_shadow_an", an_o, 8'hFE);

`ifdef SEG_SCAN_DIM_EN
    dim = 3'd1;
    for (int i = 0; i < FR; i++) step(1'b1);
    dim = 3'd7;
    for (int i = 0; i < FR; i++) step(1'b1);
`endif

    // Randomized inputs and freeze over several frames.
    for (int i = 0; i < 4 * FR; i++) begin
      if ($urandom_range(3) == 0) seg_in[$urandom_range(7)] = 8'($urandom);
      freeze = ($urandom_range(3) == 0);
`ifdef SEG_SCAN_DIM_EN
      if ($urandom_range(15) == 0) dim = 3'($urandom);
`endif
      step(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
